// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store sequencer: memory commands, register-file types
// and the sequencer state encoding.
package lsu_ctrl_pkg;

    typedef logic [31:0] rvwordT;
    typedef logic [4:0]  regT;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MemControlT;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_STORE     = 2'd1,
        LSU_LOAD_WAIT = 2'd2,
        LSU_FAULT     = 2'd3
    } LsuStateT;

    localparam regT REG_ZERO = 5'd0;

    // Only word accesses exist, so anything off a 4-byte boundary is illegal.
    function automatic logic is_word_aligned(input rvwordT addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side request, data-memory port and write-back bundle of the load/store sequencer.
// master is the sequencer itself; slave is the surrounding pipeline and memory.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic       req_valid;
    logic       req_is_store;
    rvwordT     req_addr;
    rvwordT     req_wdata;
    regT        req_rd;
    logic       req_ready;
    logic       stall;

    MemControlT dmem_control;
    rvwordT     dmem_addr;
    rvwordT     dmem_writedata;
    rvwordT     dmem_readdata;
    logic       dmem_readdata_valid;

    logic       wb_valid;
    regT        wb_reg;
    rvwordT     wb_value;

    logic       fault;
    logic       fault_clr;

    modport master (
        input  req_valid, req_is_store, req_addr, req_wdata, req_rd,
        input  dmem_readdata, dmem_readdata_valid, fault_clr,
        output req_ready, stall, dmem_control, dmem_addr, dmem_writedata,
        output wb_valid, wb_reg, wb_value, fault
    );

    modport slave (
        output req_valid, req_is_store, req_addr, req_wdata, req_rd,
        output dmem_readdata, dmem_readdata_valid, fault_clr,
        input  req_ready, stall, dmem_control, dmem_addr, dmem_writedata,
        input  wb_valid, wb_reg, wb_value, fault
    );

endinterface

// File: rtl/lsu_watchdog.sv
// Clear/enable cycle counter that flags when it has reached TIMEOUT_CYCLES-1.
module lsu_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign terminal = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !terminal) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one LW/SW at a time from execute, drives the data-memory
// port, returns load write-backs and raises a sticky fault on misalignment or timeout.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input logic      clk,
    input logic      rst,
    lsu_ctrl_if.master bus
);

    LsuStateT   state_q, state_d;
    MemControlT ctrl_q, ctrl_d;
    rvwordT     addr_q, addr_d;
    rvwordT     wdata_q, wdata_d;
    regT        rd_q, rd_d;
    logic       wb_valid_q, wb_valid_d;
    regT        wb_reg_q, wb_reg_d;
    rvwordT     wb_value_q, wb_value_d;
    logic       fault_q, fault_d;

    logic wd_clr;
    logic wd_en;
    logic wd_terminal;
    logic req_ready;

    lsu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .en       (wd_en),
        .terminal (wd_terminal)
    );

    assign req_ready          = (state_q == LSU_IDLE);
    assign bus.req_ready      = req_ready;
    assign bus.stall          = (state_q != LSU_IDLE) | (bus.req_valid & req_ready);
    assign bus.dmem_control   = ctrl_q;
    assign bus.dmem_addr      = addr_q;
    assign bus.dmem_writedata = wdata_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_reg         = wb_reg_q;
    assign bus.wb_value       = wb_value_q;
    assign bus.fault          = fault_q;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_value_d = wb_value_q;
        fault_d    = fault_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                // Holding the watchdog cleared here means every load starts counting from 0.
                wd_clr = 1'b1;
                if (bus.req_valid) begin
                    if (!is_word_aligned(bus.req_addr)) begin
                        state_d = LSU_FAULT;
                        fault_d = 1'b1;
                    end else if (bus.req_is_store) begin
                        state_d = LSU_STORE;
                        ctrl_d  = MEM_WRITE;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                    end else begin
                        state_d = LSU_LOAD_WAIT;
                        ctrl_d  = MEM_READ;
                        addr_d  = bus.req_addr;
                        rd_d    = bus.req_rd;
                    end
                end
            end

            LSU_STORE: begin
                state_d = LSU_IDLE;
                ctrl_d  = MEM_NOP;
            end

            LSU_LOAD_WAIT: begin
                wd_en = 1'b1;
                // Data arriving on the timeout cycle still completes the load.
                if (bus.dmem_readdata_valid) begin
                    state_d    = LSU_IDLE;
                    ctrl_d     = MEM_NOP;
                    wb_valid_d = (rd_q != REG_ZERO);
                    wb_reg_d   = rd_q;
                    wb_value_d = bus.dmem_readdata;
                end else if (wd_terminal) begin
                    state_d = LSU_FAULT;
                    ctrl_d  = MEM_NOP;
                    fault_d = 1'b1;
                end
            end

            LSU_FAULT: begin
                ctrl_d = MEM_NOP;
                if (bus.fault_clr) begin
                    state_d = LSU_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d = LSU_IDLE;
                ctrl_d  = MEM_NOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            ctrl_q     <= MEM_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_value_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_value_q <= wb_value_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, misalignment, timeout, x0 loads, reset mid-load.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    lsu_ctrl_if bus ();

    lsu_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; all checks happen there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid           = 1'b0;
        bus.req_is_store        = 1'b0;
        bus.req_addr            = '0;
        bus.req_wdata           = '0;
        bus.req_rd              = '0;
        bus.dmem_readdata       = '0;
        bus.dmem_readdata_valid = 1'b0;
        bus.fault_clr           = 1'b0;
    endtask

    task automatic issue(input logic is_store, input rvwordT addr, input rvwordT wdata,
                         input regT rd);
        bus.req_valid    = 1'b1;
        bus.req_is_store = is_store;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        n_cmp++;
        if (bus.dmem_control !== MEM_NOP || bus.dmem_addr !== 32'h0 ||
            bus.dmem_writedata !== 32'h0 || bus.wb_valid !== 1'b0 || bus.wb_reg !== 5'd0 ||
            bus.wb_value !== 32'h0 || bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctrl=%0d addr=%h wd=%h wbv=%b wbr=%0d wbval=%h f=%b",
                     bus.dmem_control, bus.dmem_addr, bus.dmem_writedata, bus.wb_valid,
                     bus.wb_reg, bus.wb_value, bus.fault);
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: ready=%b stall=%b, expected 1/0",
                     bus.req_ready, bus.stall);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_load();
        issue(1'b0, 32'h100, 32'h0, 5'd5);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_accept: ready=%b stall=%b, expected 1/1", bus.req_ready, bus.stall);
        end
        step();
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.dmem_control !== MEM_READ || bus.dmem_addr !== 32'h100 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_issue: ctrl=%0d addr=%h stall=%b, expected READ/100/1",
                     bus.dmem_control, bus.dmem_addr, bus.stall);
        end
        step();
        bus.dmem_readdata       = 32'hDEADBEEF;
        bus.dmem_readdata_valid = 1'b1;
        n_cmp++;
        if (bus.dmem_control !== MEM_READ || bus.wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wait: ctrl=%0d wbv=%b, expected READ/0",
                     bus.dmem_control, bus.wb_valid);
        end
        step();
        bus.dmem_readdata_valid = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg !== 5'd5 || bus.wb_value !== 32'hDEADBEEF ||
            bus.dmem_control !== MEM_NOP || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_wb: wbv=%b reg=%0d val=%h ctrl=%0d ready=%b, expected 1/5/deadbeef/NOP/1",
                     bus.wb_valid, bus.wb_reg, bus.wb_value, bus.dmem_control, bus.req_ready);
        end
        step();
        n_cmp++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wb_pulse: wbv=%b, expected 0", bus.wb_valid);
        end
    endtask

    task automatic test_store();
        issue(1'b1, 32'h204, 32'h12345678, 5'd0);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL store_stall0: stall=%b, expected 1", bus.stall);
        end
        step();
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.dmem_control !== MEM_WRITE || bus.dmem_addr !== 32'h204 ||
            bus.dmem_writedata !== 32'h12345678 || bus.stall !== 1'b1 || bus.wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_write: ctrl=%0d addr=%h wd=%h stall=%b wbv=%b, expected WRITE/204/12345678/1/0",
                     bus.dmem_control, bus.dmem_addr, bus.dmem_writedata, bus.stall, bus.wb_valid);
        end
        step();
        n_cmp++;
        if (bus.dmem_control !== MEM_NOP || bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done: ctrl=%0d stall=%b wbv=%b, expected NOP/0/0",
                     bus.dmem_control, bus.stall, bus.wb_valid);
        end
    endtask

    task automatic test_misaligned();
        issue(1'b0, 32'h102, 32'h0, 5'd4);
        step();
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.dmem_control !== MEM_NOP || bus.fault !== 1'b1 || bus.stall !== 1'b1 ||
            bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_fault: ctrl=%0d fault=%b stall=%b ready=%b, expected NOP/1/1/0",
                     bus.dmem_control, bus.fault, bus.stall, bus.req_ready);
        end
        step();
        bus.fault_clr = 1'b1;
        n_cmp++;
        if (bus.fault !== 1'b1 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_sticky: fault=%b stall=%b, expected 1/1", bus.fault, bus.stall);
        end
        step();
        bus.fault_clr = 1'b0;
        n_cmp++;
        if (bus.fault !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_clear: fault=%b ready=%b, expected 0/1",
                     bus.fault, bus.req_ready);
        end
    endtask

    task automatic test_timeout();
        issue(1'b0, 32'h40, 32'h0, 5'd3);
        for (int i = 1; i <= 64; i++) begin
            step();
            bus.req_valid = 1'b0;
        end
        n_cmp++;
        if (bus.dmem_control !== MEM_READ || bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cycle64: ctrl=%0d fault=%b, expected READ/0",
                     bus.dmem_control, bus.fault);
        end
        step();
        n_cmp++;
        if (bus.fault !== 1'b1 || bus.dmem_control !== MEM_NOP || bus.wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: fault=%b ctrl=%0d wbv=%b, expected 1/NOP/0",
                     bus.fault, bus.dmem_control, bus.wb_valid);
        end
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        issue(1'b0, 32'h44, 32'h0, 5'd6);
        for (int i = 1; i <= 64; i++) begin
            step();
            bus.req_valid = 1'b0;
        end
        bus.dmem_readdata       = 32'hCAFEF00D;
        bus.dmem_readdata_valid = 1'b1;
        step();
        bus.dmem_readdata_valid = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg !== 5'd6 || bus.wb_value !== 32'hCAFEF00D ||
            bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_race: wbv=%b reg=%0d val=%h fault=%b, expected 1/6/cafef00d/0",
                     bus.wb_valid, bus.wb_reg, bus.wb_value, bus.fault);
        end
        step();
    endtask

    task automatic test_x0_and_spurious();
        issue(1'b0, 32'h80, 32'h0, 5'd0);
        step();
        bus.req_valid           = 1'b0;
        bus.dmem_readdata       = 32'h11112222;
        bus.dmem_readdata_valid = 1'b1;
        step();
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dmem_control !== MEM_NOP || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_load: wbv=%b ctrl=%0d ready=%b, expected 0/NOP/1",
                     bus.wb_valid, bus.dmem_control, bus.req_ready);
        end
        bus.fault_clr = 1'b1;
        step();
        bus.dmem_readdata_valid = 1'b0;
        bus.fault_clr           = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dmem_control !== MEM_NOP || bus.req_ready !== 1'b1 ||
            bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: wbv=%b ctrl=%0d ready=%b fault=%b, expected 0/NOP/1/0",
                     bus.wb_valid, bus.dmem_control, bus.req_ready, bus.fault);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 32'h208, 32'hA5A5A5A5, 5'd0);
        step();
        issue(1'b0, 32'h300, 32'h0, 5'd7);
        n_cmp++;
        if (bus.req_ready !== 1'b0 || bus.dmem_control !== MEM_WRITE) begin
            n_fail++;
            $display("FAIL b2b_busy: ready=%b ctrl=%0d, expected 0/WRITE",
                     bus.req_ready, bus.dmem_control);
        end
        step();
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.dmem_control !== MEM_NOP) begin
            n_fail++;
            $display("FAIL b2b_reaccept: ready=%b ctrl=%0d, expected 1/NOP",
                     bus.req_ready, bus.dmem_control);
        end
        step();
        bus.req_valid           = 1'b0;
        bus.dmem_readdata       = 32'h000055AA;
        bus.dmem_readdata_valid = 1'b1;
        n_cmp++;
        if (bus.dmem_control !== MEM_READ || bus.dmem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL b2b_load_issue: ctrl=%0d addr=%h, expected READ/300",
                     bus.dmem_control, bus.dmem_addr);
        end
        step();
        bus.dmem_readdata_valid = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg !== 5'd7 || bus.wb_value !== 32'h000055AA) begin
            n_fail++;
            $display("FAIL b2b_wb: wbv=%b reg=%0d val=%h, expected 1/7/000055aa",
                     bus.wb_valid, bus.wb_reg, bus.wb_value);
        end
        step();
    endtask

    task automatic test_reset_mid_load();
        issue(1'b0, 32'h88, 32'h0, 5'd9);
        step();
        bus.req_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.dmem_control !== MEM_NOP || bus.dmem_addr !== 32'h0 ||
            bus.dmem_writedata !== 32'h0 || bus.wb_reg !== 5'd0 || bus.wb_value !== 32'h0 ||
            bus.wb_valid !== 1'b0 || bus.fault !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_load: ctrl=%0d addr=%h wd=%h reg=%0d val=%h wbv=%b f=%b rdy=%b",
                     bus.dmem_control, bus.dmem_addr, bus.dmem_writedata, bus.wb_reg,
                     bus.wb_value, bus.wb_valid, bus.fault, bus.req_ready);
        end
        step();
        rst = 1'b0;
        step();
        issue(1'b0, 32'h104, 32'h0, 5'd2);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.dmem_readdata       = 32'h0BADF00D;
        bus.dmem_readdata_valid = 1'b1;
        step();
        bus.dmem_readdata_valid = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg !== 5'd2 || bus.wb_value !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL post_reset_load: wbv=%b reg=%0d val=%h, expected 1/2/0badf00d",
                     bus.wb_valid, bus.wb_reg, bus.wb_value);
        end
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_x0_and_spurious();
        test_back_to_back();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
